rega_sequencer: RTL and testbench
=================================

REGA_SEQUENCER -- requirements
Module: rega_sequencer

Interface
REQ-001 Parameter WATER_TICKS, default 16: watering duration in ticks; legal range 1..255.
REQ-002 Parameter COOL_TICKS, default 8: post-watering hold-off in ticks; legal range 1..255.
REQ-003 Parameter TICK_DIV, default 4: Clk cycles per tick; legal range 1..255.
REQ-004 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Seco  input  1  soil-dry sensor, asynchronous to Clk.
REQ-007 Chuva  input  1  rain sensor, asynchronous to Clk.
REQ-008 Nivel_baixo  input  1  tank-low sensor, asynchronous to Clk.
REQ-009 Manual_on  input  1  manual watering request (level), asynchronous to Clk.
REQ-010 Ack  input  1  operator fault acknowledge, asynchronous to Clk.
REQ-011 J  output  1  one-cycle open command to the downstream valve JK flip-flop.
REQ-012 K  output  1  one-cycle close command to the downstream valve JK flip-flop.
REQ-013 Regando  output  1  high while the state is WATER.
REQ-014 Alarme  output  1  high while the state is FAULT.
REQ-015 Estado  output  2  current state code.

Function
REQ-016 Each asynchronous input SHALL pass through a 2-flop synchroniser; a sensor change SHALL be reflected in Estado 3 Clk cycles later.
REQ-017 States SHALL be IDLE=00, WATER=01, COOL=10 and FAULT=11; all outputs SHALL be registered.
REQ-018 In IDLE: synced Nivel_baixo SHALL take the FSM to FAULT; otherwise (Seco && !Chuva) || Manual_on SHALL take it to WATER; otherwise it SHALL stay in IDLE.
REQ-019 In WATER, priority SHALL be Nivel_baixo -> FAULT, then Chuva -> COOL, then timer expiry -> COOL.
REQ-020 In COOL: Nivel_baixo SHALL take the FSM to FAULT; timer expiry SHALL take it to IDLE.
REQ-021 In FAULT: a synced Ack with Nivel_baixo low SHALL take the FSM to IDLE; Ack while Nivel_baixo is high SHALL be ignored.
REQ-022 On every entry to WATER or COOL, the prescaler and tick counter SHALL clear to 0.
REQ-023 A tick SHALL occur when the prescaler equals TICK_DIV-1, after which the prescaler SHALL wrap to 0 and the counter SHALL increment.
REQ-024 Timer expiry SHALL be a tick with counter == N-1, where N is WATER_TICKS or COOL_TICKS; the state SHALL therefore last exactly N*TICK_DIV cycles when undisturbed.
REQ-025 The counter and prescaler SHALL be sized by $clog2 of their maxima and SHALL never wrap beyond N-1.
REQ-026 J SHALL be 1 only during the first cycle of WATER.
REQ-027 K SHALL be 1 only during the first cycle after leaving WATER, whatever the exit cause.
REQ-028 J and K SHALL never be 1 in the same cycle.
REQ-029 Manual_on SHALL NOT extend an active WATER; leaving WATER always passes through COOL or FAULT.

Reset
REQ-030 Reset low SHALL asynchronously force: Estado=IDLE; J=K=Regando=Alarme=0; counters and synchroniser flops to 0.
REQ-031 Reset asserted mid-WATER SHALL produce no K pulse; the downstream flip-flop SHALL share Reset.
REQ-032 Release SHALL be synchronous to Clk, and the first transition SHALL occur no earlier than 3 cycles after release.

Structure
REQ-033 Package rega_pkg SHALL hold the state encoding and the default WATER_TICKS, COOL_TICKS and TICK_DIV constants.
REQ-034 Sub-module rega_sync2 (a 2-flop synchroniser with async active-low Reset) SHALL be instantiated once per asynchronous input.

Verification
REQ-035 Reset low with random inputs -> Estado=00 and J=K=Regando=Alarme=0 immediately, without waiting for a Clk edge.
REQ-036 Defaults, Seco=1, Chuva=0, Nivel_baixo=0 -> J pulse 3 cycles after Seco rises; Regando high 64 cycles; then K pulse; COOL 32 cycles; then re-entry to WATER while Seco is held.
REQ-037 Chuva=1 at WATER cycle 20 -> K pulse and Estado=10 three cycles later; Alarme stays 0.
REQ-038 Nivel_baixo=1 in WATER -> K pulse, Estado=11, Alarme=1; Ack with Nivel_baixo=1 gives no change; Nivel_baixo=0 then Ack -> Estado=00.
REQ-039 Seco=1 and Nivel_baixo=1 rising together in IDLE -> Estado=11 and no J pulse.
REQ-040 Reset low at WATER cycle 10 -> all outputs 0 and no K pulse; after release with Seco=1 -> a fresh 64-cycle WATER.

Source files
------------

// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation sequencer: state encoding, default
// timing constants and a width helper for the prescaler/tick counters.
package rega_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WATER = 2'b01,
        COOL  = 2'b10,
        FAULT = 2'b11
    } rega_state_e;

    localparam int DEF_WATER_TICKS = 16;
    localparam int DEF_COOL_TICKS  = 8;
    localparam int DEF_TICK_DIV    = 4;

    // Counters hold 0..max_value-1, so they need $clog2(max_value) bits (at least one).
    function automatic int width_for(input int max_value);
        return (max_value > 1) ? $clog2(max_value) : 1;
    endfunction

endpackage

// File: rtl/rega_sync2.sv
// Two-flop synchroniser bringing one asynchronous sensor line into the Clk domain.
module rega_sync2 (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rega_sequencer.sv
// Irrigation valve sequencer: decides when to water, times the watering and
// hold-off phases, and issues one-cycle J/K commands to the valve flip-flop.
module rega_sequencer
    import rega_pkg::*;
#(
    parameter int WATER_TICKS = DEF_WATER_TICKS,
    parameter int COOL_TICKS  = DEF_COOL_TICKS,
    parameter int TICK_DIV    = DEF_TICK_DIV
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Seco,
    input  logic       Chuva,
    input  logic       Nivel_baixo,
    input  logic       Manual_on,
    input  logic       Ack,
    output logic       J,
    output logic       K,
    output logic       Regando,
    output logic       Alarme,
    output logic [1:0] Estado
);

    localparam int MAX_TICKS = (WATER_TICKS > COOL_TICKS) ? WATER_TICKS : COOL_TICKS;
    localparam int CNT_W     = width_for(MAX_TICKS);
    localparam int PRE_W     = width_for(TICK_DIV);

    localparam logic [CNT_W-1:0] WATER_LAST = CNT_W'(WATER_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_TICKS - 1);
    localparam logic [PRE_W-1:0] DIV_LAST   = PRE_W'(TICK_DIV - 1);

    logic seco_s, chuva_s, nivel_s, manual_s, ack_s;

    rega_sync2 u_sync_seco   (.Clk(Clk), .Reset(Reset), .d(Seco),        .q(seco_s));
    rega_sync2 u_sync_chuva  (.Clk(Clk), .Reset(Reset), .d(Chuva),       .q(chuva_s));
    rega_sync2 u_sync_nivel  (.Clk(Clk), .Reset(Reset), .d(Nivel_baixo), .q(nivel_s));
    rega_sync2 u_sync_manual (.Clk(Clk), .Reset(Reset), .d(Manual_on),   .q(manual_s));
    rega_sync2 u_sync_ack    (.Clk(Clk), .Reset(Reset), .d(Ack),         .q(ack_s));

    rega_state_e      state_q, state_d;
    logic [PRE_W-1:0] presc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_last;
    logic             timed;
    logic             tick;
    logic             expire;

    logic j_d, k_d, regando_d, alarme_d;

    assign timed    = (state_q == WATER) || (state_q == COOL);
    assign tick     = (presc_q == DIV_LAST);
    assign cnt_last = (state_q == WATER) ? WATER_LAST : COOL_LAST;
    assign expire   = timed && tick && (cnt_q == cnt_last);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any state change (or sitting in an untimed state) restarts the timer, so
    // each timed phase begins at prescaler=0, counter=0.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if ((state_d != state_q) || !timed) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (tick) begin
            presc_q <= '0;
            cnt_q   <= cnt_q + CNT_W'(1);
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (nivel_s)
                    state_d = FAULT;
                else if ((seco_s && !chuva_s) || manual_s)
                    state_d = WATER;
            end
            WATER: begin
                if (nivel_s)
                    state_d = FAULT;
                else if (chuva_s || expire)
                    state_d = COOL;
            end
            COOL: begin
                if (nivel_s)
                    state_d = FAULT;
                else if (expire)
                    state_d = IDLE;
            end
            FAULT: begin
                if (ack_s && !nivel_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming transition and registered so they
    // line up with the state they describe.
    always_comb begin
        j_d       = (state_d == WATER) && (state_q != WATER);
        k_d       = (state_q == WATER) && (state_d != WATER);
        regando_d = (state_d == WATER);
        alarme_d  = (state_d == FAULT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            J       <= 1'b0;
            K       <= 1'b0;
            Regando <= 1'b0;
            Alarme  <= 1'b0;
        end else begin
            J       <= j_d;
            K       <= k_d;
            Regando <= regando_d;
            Alarme  <= alarme_d;
        end
    end

    assign Estado = state_q;

endmodule

// File: tb/tb_rega_sequencer.sv
// Self-checking bench for rega_sequencer: directed scenarios with literal
// expectations plus randomized stimulus checked every cycle against a model.
module tb_rega_sequencer;

    localparam int WT = 16;
    localparam int CT = 8;
    localparam int TD = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Seco = 1'b0;
    logic       Chuva = 1'b0;
    logic       Nivel_baixo = 1'b0;
    logic       Manual_on = 1'b0;
    logic       Ack = 1'b0;
    logic       J, K, Regando, Alarme;
    logic [1:0] Estado;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    rega_sequencer #(
        .WATER_TICKS(WT),
        .COOL_TICKS (CT),
        .TICK_DIV   (TD)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Seco       (Seco),
        .Chuva      (Chuva),
        .Nivel_baixo(Nivel_baixo),
        .Manual_on  (Manual_on),
        .Ack        (Ack),
        .J          (J),
        .K          (K),
        .Regando    (Regando),
        .Alarme     (Alarme),
        .Estado     (Estado)
    );

    always #5 Clk = ~Clk;

    // Reference model: inputs become visible to the decision logic after two
    // edges; each timed phase ends after a plain count of cycles spent in it.
    int m_state = 0;
    int m_dwell = 0;
    int m_next  = 0;
    bit m_j = 1'b0;
    bit m_k = 1'b0;
    bit s1 [5];
    bit s2 [5];

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_state = 0;
            m_dwell = 0;
            m_j     = 1'b0;
            m_k     = 1'b0;
            for (int i = 0; i < 5; i++) begin
                s1[i] = 1'b0;
                s2[i] = 1'b0;
            end
        end else begin
            m_next = m_state;
            case (m_state)
                0: if (s2[2]) m_next = 3;
                   else if ((s2[0] && !s2[1]) || s2[3]) m_next = 1;
                1: if (s2[2]) m_next = 3;
                   else if (s2[1] || (m_dwell == WT*TD - 1)) m_next = 2;
                2: if (s2[2]) m_next = 3;
                   else if (m_dwell == CT*TD - 1) m_next = 0;
                default: if (s2[4] && !s2[2]) m_next = 0;
            endcase
            m_j     = (m_next == 1) && (m_state != 1);
            m_k     = (m_state == 1) && (m_next != 1);
            m_dwell = (m_next != m_state) ? 0 : m_dwell + 1;
            m_state = m_next;
            s2 = s1;
            s1[0] = Seco;
            s1[1] = Chuva;
            s1[2] = Nivel_baixo;
            s1[3] = Manual_on;
            s1[4] = Ack;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit seco, input bit chuva, input bit low, input bit man, input bit ack);
        Seco        = seco;
        Chuva       = chuva;
        Nivel_baixo = low;
        Manual_on   = man;
        Ack         = ack;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            checkOutput("model_estado",  32'(Estado),  32'(m_state));
            checkOutput("model_j",       32'(J),       32'(m_j));
            checkOutput("model_k",       32'(K),       32'(m_k));
            checkOutput("model_regando", 32'(Regando), 32'(m_state == 1));
            checkOutput("model_alarme",  32'(Alarme),  32'(m_state == 3));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int len;
        bit seen;

        #1;
        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        Reset = 1'b0;
        #1;
        checkOutput("rst_estado",  32'(Estado),  32'd0);
        checkOutput("rst_j",       32'(J),       32'd0);
        checkOutput("rst_k",       32'(K),       32'd0);
        checkOutput("rst_regando", 32'(Regando), 32'd0);
        checkOutput("rst_alarme",  32'(Alarme),  32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        chk_en = 1'b1;
        waitNeg(3);
        Reset = 1'b1;
        waitNeg(4);

        $display("[TB] normal watering cycle");
        applyStimulus(1, 0, 0, 0, 0);
        lat = 0;
        do begin @(negedge Clk); lat++; end while (J !== 1'b1 && lat < 10);
        checkOutput("j_latency", lat, 32'd3);
        checkOutput("regando_at_j", 32'(Regando), 32'd1);
        len = 0;
        while (Regando === 1'b1 && len < 200) begin len++; @(negedge Clk); end
        checkOutput("water_len", len, 32'd64);
        checkOutput("k_after_water", 32'(K), 32'd1);
        checkOutput("estado_cool", 32'(Estado), 32'd2);
        len = 0;
        while (Estado === 2'b10 && len < 200) begin len++; @(negedge Clk); end
        checkOutput("cool_len", len, 32'd32);
        checkOutput("idle_gap", 32'(Estado), 32'd0);
        @(negedge Clk);
        checkOutput("rewater_j", 32'(J), 32'd1);
        checkOutput("rewater_estado", 32'(Estado), 32'd1);

        $display("[TB] rain during watering");
        waitNeg(19);
        applyStimulus(1, 1, 0, 0, 0);
        waitNeg(2);
        checkOutput("rain_hold", 32'(Estado), 32'd1);
        waitNeg(1);
        checkOutput("rain_estado", 32'(Estado), 32'd2);
        checkOutput("rain_k", 32'(K), 32'd1);
        checkOutput("rain_alarme", 32'(Alarme), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        len = 0;
        while (Estado !== 2'b00 && len < 100) begin len++; @(negedge Clk); end
        checkOutput("rain_to_idle", 32'(Estado), 32'd0);

        $display("[TB] tank low during watering");
        applyStimulus(1, 0, 0, 0, 0);
        len = 0;
        while (Regando !== 1'b1 && len < 10) begin len++; @(negedge Clk); end
        waitNeg(5);
        applyStimulus(1, 0, 1, 0, 0);
        waitNeg(3);
        checkOutput("low_estado", 32'(Estado), 32'd3);
        checkOutput("low_k", 32'(K), 32'd1);
        checkOutput("low_alarme", 32'(Alarme), 32'd1);
        applyStimulus(1, 0, 1, 0, 1);
        waitNeg(6);
        checkOutput("ack_ignored", 32'(Estado), 32'd3);
        applyStimulus(0, 0, 0, 0, 0);
        waitNeg(4);
        applyStimulus(0, 0, 0, 0, 1);
        waitNeg(3);
        checkOutput("ack_clear", 32'(Estado), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        waitNeg(4);

        $display("[TB] dry and tank low together");
        applyStimulus(1, 0, 1, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (J === 1'b1) seen = 1'b1;
            if (i == 2) checkOutput("both_fault", 32'(Estado), 32'd3);
        end
        checkOutput("both_no_j", 32'(seen), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        waitNeg(4);
        applyStimulus(0, 0, 0, 0, 1);
        waitNeg(4);
        applyStimulus(0, 0, 0, 0, 0);
        waitNeg(4);
        checkOutput("both_recover", 32'(Estado), 32'd0);

        $display("[TB] reset during watering");
        applyStimulus(1, 0, 0, 0, 0);
        len = 0;
        while (J !== 1'b1 && len < 10) begin len++; @(negedge Clk); end
        waitNeg(9);
        #2 Reset = 1'b0;
        #1;
        checkOutput("midrst_estado",  32'(Estado),  32'd0);
        checkOutput("midrst_j",       32'(J),       32'd0);
        checkOutput("midrst_k",       32'(K),       32'd0);
        checkOutput("midrst_regando", 32'(Regando), 32'd0);
        checkOutput("midrst_alarme",  32'(Alarme),  32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (K === 1'b1) seen = 1'b1;
        end
        checkOutput("midrst_no_k", 32'(seen), 32'd0);
        Reset = 1'b1;
        lat = 0;
        do begin @(negedge Clk); lat++; end while (J !== 1'b1 && lat < 10);
        checkOutput("post_rst_j_latency", lat, 32'd3);
        len = 0;
        while (Regando === 1'b1 && len < 200) begin len++; @(negedge Clk); end
        checkOutput("post_rst_water_len", len, 32'd64);
        applyStimulus(0, 0, 0, 0, 0);
        len = 0;
        while (Estado !== 2'b00 && len < 200) begin len++; @(negedge Clk); end
        checkOutput("post_rst_idle", 32'(Estado), 32'd0);

        $display("[TB] randomized phase");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge Clk);
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus($urandom_range(0, 2) != 0,
                              $urandom_range(0, 4) == 0,
                              $urandom_range(0, 9) == 0,
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset = 1'b0;
                #1 checkOutput("rand_rst_estado", 32'(Estado), 32'd0);
                waitNeg(2);
                Reset = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
